// File: rtl/piso_bit_serializer_pkg.sv
// Shared definitions for the PISO bit serializer and the sequence-detector
// chain it feeds.
//   state_e   : serializer FSM state codes (2-bit; code 3 is illegal).
//   ser_bit_t : one serial bit, as consumed by the detector's serial input.
//   cnt_w()   : bit-counter width for a given word width.
package piso_bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int SER_BIT_W = 1;
  typedef logic [SER_BIT_W-1:0] ser_bit_t;

  localparam int GCNT_W = 4;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_serializer_hold_reg.sv
// One-word holding register with its full flag.
// Ports:
//   clk, res_n     clock, async active-low reset
//   clr            drop the held word (used for illegal-state recovery)
//   wr_en/wr_data  capture a word; wins over rd_en on the same edge
//   rd_en          held word consumed this edge
//   full/data      registered flag and held word
module piso_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (wr_en) begin
      // A write on the same edge as a read refills the register.
      hold_d = wr_data;
      full_d = 1'b1;
    end else if (rd_en) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign full = full_q;
  assign data = hold_q;

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out front end for the Moore sequence detector.
// Takes WIDTH-bit words on a valid/ready handshake and emits one bit per
// clock. A one-word holding register lets consecutive words stream without
// a bubble; GAP_CYCLES idle cycles may be forced after each word.
// Ports:
//   clk, res_n    clock, async active-low reset
//   din/din_valid parallel word and its valid
//   din_ready     registered: !hold_full
//   bit_out       serial bit, 0 when bit_valid=0
//   bit_valid     bit_out carries data
//   frame_start   first bit of each word
//   busy          FSM active or a word is held
module piso_bit_serializer
  import piso_bit_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int                CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;

  logic                hold_full, hold_wr, hold_rd, hold_clr;
  logic [WIDTH-1:0]    hold_data;
  logic                accept;
  logic [WIDTH-1:0]    sreg_shifted;
  ser_bit_t            out_bit;

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .res_n   (res_n),
    .clr     (hold_clr),
    .wr_en   (hold_wr),
    .wr_data (din),
    .rd_en   (hold_rd),
    .full    (hold_full),
    .data    (hold_data)
  );

  // Ready depends only on the registered flag, never on din_valid.
  assign din_ready = ~hold_full;
  assign accept    = din_valid & ~hold_full;

  generate
    if (MSB_FIRST) begin : g_msb
      assign out_bit      = sreg_q[WIDTH-1];
      assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign out_bit      = sreg_q[0];
      assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    hold_wr     = 1'b0;
    hold_rd     = 1'b0;
    hold_clr    = 1'b0;
    bit_valid   = 1'b0;
    bit_out     = 1'b0;
    frame_start = 1'b0;
    busy        = hold_full;

    case (state_q)
      IDLE: begin
        // The holding register is never written here: a word goes straight
        // into the shifter.
        if (accept) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        busy        = 1'b1;
        bit_valid   = 1'b1;
        bit_out     = out_bit;
        frame_start = (cnt_q == '0);
        sreg_d      = sreg_shifted;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gcnt_d  = '0;
            hold_wr = accept;
          end else if (hold_full) begin
            sreg_d  = hold_data;
            hold_rd = 1'b1;
            hold_wr = accept;
          end else if (accept) begin
            // Bypass: the arriving word feeds the shifter directly so the
            // stream stays contiguous.
            sreg_d = din;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_wr = accept;
        end
      end

      GAP: begin
        busy   = 1'b1;
        gcnt_d = gcnt_q + GCNT_W'(1);
        if (gcnt_q == GAP_LAST) begin
          gcnt_d = '0;
          cnt_d  = '0;
          if (hold_full) begin
            state_d = SHIFT;
            sreg_d  = hold_data;
            hold_rd = 1'b1;
            hold_wr = accept;
          end else if (accept) begin
            state_d = SHIFT;
            sreg_d  = din;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_wr = accept;
        end
      end

      default: begin
        // Unused encoding: behave as if just reset.
        state_d  = IDLE;
        sreg_d   = '0;
        cnt_d    = '0;
        gcnt_d   = '0;
        hold_clr = 1'b1;
        busy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
module tb_piso_bit_serializer;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] din0, din1, din2;
  logic       dv0, dv1, dv2;
  logic       dr0, dr1, dr2;
  logic       bo0, bo1, bo2;
  logic       bv0, bv1, bv2;
  logic       fs0, fs1, fs2;
  logic       bz0, bz1, bz2;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut (
    .clk(clk), .res_n(res_n), .din(din0), .din_valid(dv0), .din_ready(dr0),
    .bit_out(bo0), .bit_valid(bv0), .frame_start(fs0), .busy(bz0));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_gap (
    .clk(clk), .res_n(res_n), .din(din1), .din_valid(dv1), .din_ready(dr1),
    .bit_out(bo1), .bit_valid(bv1), .frame_start(fs1), .busy(bz1));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
    .clk(clk), .res_n(res_n), .din(din2), .din_valid(dv2), .din_ready(dr2),
    .bit_out(bo2), .bit_valid(bv2), .frame_start(fs2), .busy(bz2));

  int total = 0;
  int bad   = 0;

  // Scoreboards: {expected bit, expected frame_start}
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];

  // Monitor-side statistics
  int       vcnt0 = 0, drlow0 = 0, det0 = 0;
  logic [3:0] hist0 = '0;
  logic     prev_v0 = 1'b0;
  int       cyc1 = 0, vcnt1 = 0, first1 = -1, last1 = -1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop(input int k, output logic [1:0] e);
    case (k)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic flush(input int k);
    case (k)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic push_word(input int k, input logic [7:0] w, input logic msb);
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      e = {(msb ? w[7-i] : w[i]), (i == 0)};
      case (k)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic drive(input int k, input logic [7:0] w, input logic v);
    case (k)
      0: begin din0 = w; dv0 = v; end
      1: begin din1 = w; dv1 = v; end
      default: begin din2 = w; dv2 = v; end
    endcase
  endtask

  function automatic logic rdy(input int k);
    case (k)
      0: return dr0;
      1: return dr1;
      default: return dr2;
    endcase
  endfunction

  function automatic logic bsy(input int k);
    case (k)
      0: return bz0;
      1: return bz1;
      default: return bz2;
    endcase
  endfunction

  // Present a word and hold it until the handshake completes; returns at
  // accept-edge + 1 with the number of edges waited.
  task automatic send(input int k, input logic [7:0] w, input logic msb, output int waits);
    logic r;
    int   n;
    drive(k, w, 1'b1);
    push_word(k, w, msb);
    n = 0;
    r = 1'b0;
    while (!r && n < 100) begin
      r = rdy(k);
      @(posedge clk); #1;
      n++;
    end
    if (!r) chk("send_timeout", 32'(n), 32'd0);
    waits = n;
  endtask

  task automatic wait_idle(input int k, input string tag);
    int n;
    n = 0;
    while (bsy(k) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(bsy(k)), 32'd0);
    chk({tag, "_drained"}, 32'(qsize(k)), 32'd0);
  endtask

  task automatic mon(input int k, input logic v, input logic b, input logic f);
    logic [1:0] e;
    if (v) begin
      chk($sformatf("unexpected_bit%0d", k), 32'(qsize(k) != 0), 32'd1);
      if (qsize(k) != 0) begin
        pop(k, e);
        chk($sformatf("bit_out%0d", k), 32'(b), 32'(e[1]));
        chk($sformatf("frame_start%0d", k), 32'(f), 32'(e[0]));
      end
    end else begin
      chk($sformatf("idle_bit_out%0d", k), 32'(b), 32'd0);
      chk($sformatf("idle_frame_start%0d", k), 32'(f), 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, bv0, bo0, fs0);
      mon(1, bv1, bo1, fs1);
      mon(2, bv2, bo2, fs2);
      if (bv0) begin
        vcnt0++;
        hist0 = {hist0[2:0], bo0};
        if (hist0 == 4'b1011) det0++;
      end
      if (!dr0) drlow0++;
      // A valid run on the GAP=0 instance may only end once no word is pending.
      if (prev_v0 && !bv0) chk("contiguous0", 32'(q0.size()), 32'd0);
      prev_v0 = bv0;
      cyc1++;
      if (bv1) begin
        vcnt1++;
        if (first1 < 0) first1 = cyc1;
        last1 = cyc1;
      end
    end
  end

  initial begin
    int w;
    res_n = 1'b0;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);
    #2;
    chk("rst_din_ready", 32'(dr0), 32'd1);
    chk("rst_bit_valid", 32'(bv0), 32'd0);
    chk("rst_bit_out", 32'(bo0), 32'd0);
    chk("rst_frame_start", 32'(fs0), 32'd0);
    chk("rst_busy", 32'(bz0), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    res_n = 1'b1;
    @(posedge clk); #1;

    // Single word, MSB first: 1,0,1,1,0,0,0,0 with one-cycle latency.
    hist0 = '0; det0 = 0; vcnt0 = 0;
    send(0, 8'hB0, 1'b1, w);
    drive(0, 8'h00, 1'b0);
    chk("lat_bit_valid", 32'(bv0), 32'd1);
    chk("lat_frame_start", 32'(fs0), 32'd1);
    chk("lat_bit_out", 32'(bo0), 32'd1);
    wait_idle(0, "single_idle");
    chk("single_bits", 32'(vcnt0), 32'd8);
    chk("detect_1011", 32'(det0), 32'd1);

    // Back-to-back: second word lands in hold one edge before the last bit.
    @(posedge clk); #1;
    vcnt0 = 0; drlow0 = 0;
    send(0, 8'hB0, 1'b1, w);
    drive(0, 8'h00, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    send(0, 8'h0D, 1'b1, w);
    drive(0, 8'h00, 1'b0);
    chk("b2b_ready_low", 32'(dr0), 32'd0);
    @(posedge clk); #1;
    chk("b2b_ready_back", 32'(dr0), 32'd1);
    wait_idle(0, "b2b_idle");
    chk("b2b_bits", 32'(vcnt0), 32'd16);
    chk("b2b_ready_low_cycles", 32'(drlow0), 32'd1);

    // Three words with valid held: third stalls until first word's last bit.
    @(posedge clk); #1;
    vcnt0 = 0;
    send(0, 8'hC3, 1'b1, w);
    chk("stream_w0_wait", 32'(w), 32'd1);
    send(0, 8'h5A, 1'b1, w);
    chk("stream_w1_wait", 32'(w), 32'd1);
    send(0, 8'h96, 1'b1, w);
    chk("stream_w2_wait", 32'(w), 32'd8);
    drive(0, 8'h00, 1'b0);
    wait_idle(0, "stream_idle");
    chk("stream_bits", 32'(vcnt0), 32'd24);

    // GAP_CYCLES=2: exactly two idle cycles between two words.
    vcnt1 = 0; first1 = -1; last1 = -1;
    send(1, 8'hA5, 1'b1, w);
    send(1, 8'h3C, 1'b1, w);
    drive(1, 8'h00, 1'b0);
    wait_idle(1, "gap_idle");
    chk("gap_bits", 32'(vcnt1), 32'd16);
    chk("gap_span", 32'(last1 - first1 + 1), 32'd18);

    // LSB first: 8'h0D -> 1,0,1,1,0,0,0,0.
    send(2, 8'h0D, 1'b0, w);
    drive(2, 8'h00, 1'b0);
    chk("lsb_first_bit", 32'(bo2), 32'd1);
    wait_idle(2, "lsb_idle");

    // Reset mid-word (inst0 also holding a second word).
    drive(0, 8'hE7, 1'b1); push_word(0, 8'hE7, 1'b1);
    drive(2, 8'h0D, 1'b1); push_word(2, 8'h0D, 1'b0);
    @(posedge clk); #1;
    drive(0, 8'h81, 1'b1); push_word(0, 8'h81, 1'b1);
    drive(2, 8'h00, 1'b0);
    @(posedge clk); #1;
    drive(0, 8'h00, 1'b0);
    chk("pre_rst_hold_full", 32'(dr0), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_n = 1'b0;
    flush(0); flush(2);
    #1;
    chk("arst_din_ready0", 32'(dr0), 32'd1);
    chk("arst_bit_valid0", 32'(bv0), 32'd0);
    chk("arst_bit_out0", 32'(bo0), 32'd0);
    chk("arst_frame_start0", 32'(fs0), 32'd0);
    chk("arst_busy0", 32'(bz0), 32'd0);
    chk("arst_din_ready2", 32'(dr2), 32'd1);
    chk("arst_bit_valid2", 32'(bv2), 32'd0);
    chk("arst_busy2", 32'(bz2), 32'd0);
    @(posedge clk); #1;
    res_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy0", 32'(bz0), 32'd0);
    send(2, 8'h0D, 1'b0, w);
    drive(2, 8'h00, 1'b0);
    chk("post_rst_frame_start", 32'(fs2), 32'd1);
    wait_idle(2, "post_rst_idle");
    wait_idle(0, "post_rst_idle0");

    @(posedge clk); #1;
    chk("final_q0", 32'(q0.size()), 32'd0);
    chk("final_q1", 32'(q1.size()), 32'd0);
    chk("final_q2", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
